// File: rtl/noc_sched_pkg.sv
// Shared types and helpers for the mesh-router output-port scheduler.
// Port codes, crossbar idle code, FSM states and requester-to-port mapping.
package noc_sched_pkg;

    typedef enum logic [2:0] {
        N = 3'd0,
        S = 3'd1,
        W = 3'd2,
        E = 3'd3,
        L = 3'd4
    } port_e;

    localparam logic [2:0] CS_NONE = 3'b111;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } sched_state_e;

    // Requesters are the four ports other than self, in N,S,W,E,L order.
    function automatic logic [2:0] req2port(input port_e self_port, input logic [1:0] k);
        logic [2:0] kk;
        kk = {1'b0, k};
        return (kk < 3'(self_port)) ? kk : kk + 3'd1;
    endfunction

endpackage

// File: rtl/noc_outport_scheduler_rr_pick4.sv
// Combinational rotating first-one picker over four requesters.
// Search order is ptr, ptr+1, ptr+2, ptr+3 (mod 4).
module rr_pick4 (
    input  logic [3:0] req,
    input  logic [1:0] ptr,
    output logic       valid,
    output logic [1:0] idx
);

    always_comb begin
        valid = 1'b0;
        idx   = ptr;
        // Walk offsets from farthest to nearest so the nearest hit wins.
        for (int i = 3; i >= 0; i--) begin
            if (req[ptr + 2'(i)]) begin
                valid = 1'b1;
                idx   = ptr + 2'(i);
            end
        end
    end

endmodule

// File: rtl/noc_outport_scheduler.sv
// Output-port scheduler: round-robin arbitration with wormhole lock and credit tracking.
// Optional stall-cycle counter enabled by defining NOC_SCHED_STALL_CNT_EN.
//
// state | meaning
// IDLE  | port free; arbitrate among requesters, no flit sent
// BUSY  | port locked to owner until its tail flit is sent
module noc_outport_scheduler
    import noc_sched_pkg::*;
#(
    parameter port_e SELF_PORT   = S,
    parameter int    MAX_CREDITS = 4,
    parameter int    CW          = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [3:0]    req_i,
    input  logic [3:0]    tail_i,
    input  logic          credit_ret_i,
    output logic [3:0]    grant_o,
    output logic          send_o,
    output logic [2:0]    cs_sel_o,
    output logic [CW-1:0] credit_cnt_o,
    output logic          busy_o,
    output logic          ovf_err_o,
    output logic [15:0]   stall_cnt_o
);

    localparam logic [CW-1:0] MAX_C = CW'(MAX_CREDITS);

    sched_state_e  state_q, state_d;
    logic [1:0]    owner_q, owner_d;
    logic [1:0]    rr_ptr_q, rr_ptr_d;
    logic [CW-1:0] credit_q, credit_d;
    logic          ovf_q, ovf_d;

    logic          pick_valid;
    logic [1:0]    pick_idx;
    logic          credit_nz;
    logic          send;

    rr_pick4 u_pick (
        .req   (req_i),
        .ptr   (rr_ptr_q),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    assign credit_nz = (credit_q != '0);
    assign send      = (state_q == BUSY) && req_i[owner_q] && credit_nz;

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        rr_ptr_d = rr_ptr_q;
        case (state_q)
            IDLE: begin
                if (pick_valid && credit_nz) begin
                    state_d = BUSY;
                    owner_d = pick_idx;
                end
            end
            BUSY: begin
                // Owner dropping req_i mid-packet keeps the lock.
                if (send && tail_i[owner_q]) begin
                    state_d  = IDLE;
                    rr_ptr_d = owner_q + 2'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        credit_d = credit_q;
        ovf_d    = ovf_q;
        case ({send, credit_ret_i})
            2'b10: credit_d = credit_q - 1'b1;
            2'b01: begin
                if (credit_q == MAX_C) begin
                    ovf_d = 1'b1;
                end else begin
                    credit_d = credit_q + 1'b1;
                end
            end
            default: credit_d = credit_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            owner_q  <= 2'd0;
            rr_ptr_q <= 2'd0;
            credit_q <= MAX_C;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
            credit_q <= credit_d;
            ovf_q    <= ovf_d;
        end
    end

    assign grant_o      = send ? (4'b0001 << owner_q) : 4'b0000;
    assign send_o       = send;
    assign busy_o       = (state_q == BUSY);
    assign cs_sel_o     = (state_q == BUSY) ? req2port(SELF_PORT, owner_q) : CS_NONE;
    assign credit_cnt_o = credit_q;
    assign ovf_err_o    = ovf_q;

`ifdef NOC_SCHED_STALL_CNT_EN
    logic [15:0] stall_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_q <= 16'h0;
        end else if ((state_q == BUSY) && req_i[owner_q] && !credit_nz && (stall_q != 16'hFFFF)) begin
            stall_q <= stall_q + 16'h1;
        end
    end

    assign stall_cnt_o = stall_q;
`else
    assign stall_cnt_o = 16'h0;
`endif

endmodule
